// File: rtl/branch_resolve_unit.sv
// Branch condition unit: per-accumulator Z/N/C flags with write bypass, 1-cycle
// registered branch resolution, 2-bit saturating BHT predictor and statistics.
module branch_resolve_unit #(
  parameter int unsigned NUM_ACC  = 2,
  parameter int unsigned ACC_W    = 1,
  parameter int unsigned PC_W     = 10,
  parameter int unsigned BHT_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [ACC_W-1:0] flag_sel,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             flag_c,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_taken,
  input  logic             br_valid,
  input  logic [2:0]       br_code,
  input  logic [ACC_W-1:0] br_acc,
  input  logic [PC_W-1:0]  br_pc,
  input  logic             br_pred,
  output logic             res_valid,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned BHT_DEPTH = 2 ** BHT_BITS;

  logic [NUM_ACC-1:0]  z_q, n_q, c_q;
  logic [1:0]          bht [BHT_DEPTH];
  logic [BHT_BITS-1:0] fetch_idx, br_idx;
  logic                acc_ok_c, src_z_c, src_n_c, src_c_c, cond_c, eff_c;
  logic                unused_pc_bits;

  assign fetch_idx      = fetch_pc[BHT_BITS-1:0];
  assign br_idx         = br_pc[BHT_BITS-1:0];
  assign pred_taken     = bht[fetch_idx][1];
  assign eff_c          = br_valid && (br_code != 3'd0);
  assign unused_pc_bits = ^{fetch_pc[PC_W-1:BHT_BITS], br_pc[PC_W-1:BHT_BITS]};

  // Flag source: stored set, overridden by a same-cycle write to the tested accumulator
  always_comb begin
    acc_ok_c = 1'b0;
    src_z_c  = 1'b0;
    src_n_c  = 1'b0;
    src_c_c  = 1'b0;
    for (int i = 0; i < int'(NUM_ACC); i++) begin
      if (br_acc == ACC_W'(i)) begin
        acc_ok_c = 1'b1;
        src_z_c  = z_q[i];
        src_n_c  = n_q[i];
        src_c_c  = c_q[i];
      end
    end
    if (acc_ok_c && flag_we && (flag_sel == br_acc)) begin
      src_z_c = flag_z;
      src_n_c = flag_n;
      src_c_c = flag_c;
    end
  end

  always_comb begin
    cond_c = 1'b0;
    case (br_code)
      3'd1:    cond_c = src_z_c;
      3'd2:    cond_c = !src_z_c;
      3'd3:    cond_c = src_c_c;
      3'd4:    cond_c = !src_c_c;
      3'd5:    cond_c = src_n_c;
      3'd6:    cond_c = !src_n_c;
      3'd7:    cond_c = 1'b1;
      default: cond_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
      n_q <= '0;
      c_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_ACC); i++) begin
        if (flag_we && (flag_sel == ACC_W'(i))) begin
          z_q[i] <= flag_z;
          n_q[i] <= flag_n;
          c_q[i] <= flag_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      res_valid  <= eff_c;
      taken      <= eff_c && cond_c;
      mispredict <= eff_c && (cond_c != br_pred);
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (eff_c) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if ((cond_c != br_pred) && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht[i] <= 2'b01;
    end else if (eff_c) begin
      if (cond_c) begin
        if (bht[br_idx] != 2'b11) bht[br_idx] <= bht[br_idx] + 2'd1;
      end else begin
        if (bht[br_idx] != 2'b00) bht[br_idx] <= bht[br_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: reference model feeds an expectation queue that is
// popped after every clock; a second instance covers odd NUM_ACC and narrow counters.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       flag_we, flag_z, flag_n, flag_c, pred_taken;
  logic [0:0] flag_sel, br_acc;
  logic [9:0] fetch_pc, br_pc;
  logic       br_valid, br_pred, res_valid, taken, mispredict;
  logic [2:0] br_code;
  logic [15:0] branch_cnt, mispred_cnt;

  logic       b_flag_we, b_flag_z, b_flag_n, b_flag_c, b_pred_taken;
  logic [1:0] b_flag_sel, b_br_acc;
  logic [9:0] b_fetch_pc, b_br_pc;
  logic       b_br_valid, b_br_pred, b_res_valid, b_taken, b_mispredict;
  logic [2:0] b_br_code;
  logic [3:0] b_branch_cnt, b_mispred_cnt;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_sel(flag_sel),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .br_valid(br_valid), .br_code(br_code),
    .br_acc(br_acc), .br_pc(br_pc), .br_pred(br_pred), .res_valid(res_valid),
    .taken(taken), .mispredict(mispredict), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  branch_resolve_unit #(.NUM_ACC(3), .ACC_W(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flag_we(b_flag_we), .flag_sel(b_flag_sel),
    .flag_z(b_flag_z), .flag_n(b_flag_n), .flag_c(b_flag_c), .fetch_pc(b_fetch_pc),
    .pred_taken(b_pred_taken), .br_valid(b_br_valid), .br_code(b_br_code),
    .br_acc(b_br_acc), .br_pc(b_br_pc), .br_pred(b_br_pred), .res_valid(b_res_valid),
    .taken(b_taken), .mispredict(b_mispredict), .branch_cnt(b_branch_cnt),
    .mispred_cnt(b_mispred_cnt)
  );

  typedef struct packed {
    logic        rv;
    logic        tk;
    logic        mp;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  logic m_z[2], m_n[2], m_c[2];
  logic [1:0] m_bht[16];
  logic [15:0] m_bcnt, m_mcnt;

  function automatic string obs_str();
    return $sformatf("rv=%b tk=%b mp=%b bc=%0d mc=%0d", res_valid, taken, mispredict,
                     branch_cnt, mispred_cnt);
  endfunction

  function automatic string exp_str(input exp_t e);
    return $sformatf("rv=%b tk=%b mp=%b bc=%0d mc=%0d", e.rv, e.tk, e.mp, e.bc, e.mc);
  endfunction

  function automatic logic cond_of(input logic [2:0] code, input logic z, n, c);
    case (code)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return n;
      3'd6: return !n;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_z[i] = 1'b0; m_n[i] = 1'b0; m_c[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_bcnt = '0;
    m_mcnt = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus on the main instance and queue its expected result
  task automatic issue(input logic v, input logic [2:0] code, input int acc,
                       input logic [9:0] pc, input logic pred, input logic we,
                       input int sel, input logic z, input logic n, input logic c);
    logic fz, fn, fc, r;
    exp_t e;
    int idx;
    br_valid = v; br_code = code; br_acc = 1'(acc); br_pc = pc; br_pred = pred;
    flag_we = we; flag_sel = 1'(sel); flag_z = z; flag_n = n; flag_c = c;
    if (we && sel == acc) begin
      fz = z; fn = n; fc = c;
    end else begin
      fz = m_z[acc]; fn = m_n[acc]; fc = m_c[acc];
    end
    r = cond_of(code, fz, fn, fc);
    e = '0;
    if (v && code != 3'd0) begin
      e.rv = 1'b1;
      e.tk = r;
      e.mp = (r != pred);
      if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
      if (e.mp && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
      idx = int'(pc[3:0]);
      if (r) begin
        if (m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
      end else begin
        if (m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
      end
    end
    e.bc = m_bcnt;
    e.mc = m_mcnt;
    if (we) begin
      m_z[sel] = z; m_n[sel] = n; m_c[sel] = c;
    end
    exp_q.push_back(e);
  endtask

  task automatic step_pop(output exp_t e);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    fetch_pc = '0;
    issue(1'b0, 3'd0, 0, 10'h000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    b_flag_we = 1'b0; b_flag_sel = '0; b_flag_z = 1'b0; b_flag_n = 1'b0; b_flag_c = 1'b0;
    b_fetch_pc = '0; b_br_valid = 1'b0; b_br_code = '0; b_br_acc = '0; b_br_pc = '0;
    b_br_pred = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %s expected all zero", obs_str());
    end
    checks++;
    if ({b_res_valid, b_taken, b_mispredict, b_branch_cnt, b_mispred_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %b expected 0",
               {b_res_valid, b_taken, b_mispredict, b_branch_cnt, b_mispred_cnt});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 10'(i) | 10'h2C0;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL reset_bht[%0d]: got %b expected 0", i, pred_taken);
      end
    end
  endtask

  task automatic test_flags();
    exp_t e;
    issue(1'b0, 3'd0, 0, 10'h000, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e) begin
      errors++;
      $display("FAIL flag_write_idle: got %s expected %s", obs_str(), exp_str(e));
    end
    issue(1'b1, 3'd1, 1, 10'h100, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e) begin
      errors++;
      $display("FAIL beq_acc1: got %s expected %s", obs_str(), exp_str(e));
    end
    checks++;
    if ({taken, mispredict, branch_cnt, mispred_cnt} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL beq_acc1_const: got %s expected tk=1 mp=1 bc=1 mc=1", obs_str());
    end
    issue(1'b1, 3'd1, 0, 10'h100, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e || taken !== 1'b0) begin
      errors++;
      $display("FAIL beq_acc0: got %s expected %s", obs_str(), exp_str(e));
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    issue(1'b1, 3'd3, 0, 10'h200, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e || taken !== 1'b1) begin
      errors++;
      $display("FAIL bypass_bcs: got %s expected %s", obs_str(), exp_str(e));
    end
  endtask

  task automatic test_predictor();
    exp_t e;
    logic old_p;
    logic pa[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fetch_pc = 10'h005;
    for (int k = 0; k < 7; k++) begin
      old_p = m_bht[5][1];
      issue(1'b1, (k < 4) ? 3'd7 : 3'd1, 0, 10'h025, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (pred_taken !== old_p) begin
        errors++;
        $display("FAIL pred_same_cycle[%0d]: got %b expected %b", k, pred_taken, old_p);
      end
      step_pop(e);
      checks++;
      if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e) begin
        errors++;
        $display("FAIL pred_branch[%0d]: got %s expected %s", k, obs_str(), exp_str(e));
      end
      checks++;
      if (pred_taken !== pa[k] || pred_taken !== m_bht[5][1]) begin
        errors++;
        $display("FAIL pred_after[%0d]: got %b expected %b", k, pred_taken, pa[k]);
      end
    end
  endtask

  task automatic test_codes();
    exp_t e;
    logic [2:0] cb;
    logic [15:0] bc0, mc0;
    for (int combo = 0; combo < 8; combo++) begin
      cb = 3'(combo);
      issue(1'b0, 3'd0, 0, 10'h000, 1'b0, 1'b1, 0, cb[2], cb[1], cb[0]);
      step_pop(e);
      for (int code = 1; code < 8; code++) begin
        issue(1'b1, 3'(code), 0, 10'(combo * 16), 1'($urandom_range(0, 1)),
              1'b0, 0, 1'b0, 1'b0, 1'b0);
        step_pop(e);
        checks++;
        if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e) begin
          errors++;
          $display("FAIL code%0d_znc%0b: got %s expected %s", code, cb, obs_str(), exp_str(e));
        end
      end
    end
    bc0 = m_bcnt;
    mc0 = m_mcnt;
    issue(1'b1, 3'd0, 0, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e ||
        res_valid !== 1'b0 || branch_cnt !== bc0 || mispred_cnt !== mc0) begin
      errors++;
      $display("FAIL code0: got %s expected %s", obs_str(), exp_str(e));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int idx;
    for (int k = 0; k < 60; k++) begin
      issue(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idx = int'($urandom_range(0, 15));
      fetch_pc = 10'(idx) | 10'h140;
      step_pop(e);
      checks++;
      if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: got %s expected %s", k, obs_str(), exp_str(e));
      end
      checks++;
      if (pred_taken !== m_bht[idx][1]) begin
        errors++;
        $display("FAIL b2b_pred[%0d]: got %b expected %b", k, pred_taken, m_bht[idx][1]);
      end
    end
    issue(1'b0, 3'd0, 0, 10'h000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step_pop(e);
  endtask

  task automatic test_saturation();
    int ex;
    b_br_valid = 1'b1; b_br_code = 3'd7; b_br_acc = 2'd0; b_br_pred = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      ex = (k + 1 > 15) ? 15 : k + 1;
      checks++;
      if (b_branch_cnt !== 4'(ex) || b_mispred_cnt !== 4'(ex) || b_mispredict !== 1'b1) begin
        errors++;
        $display("FAIL sat[%0d]: got bc=%0d mc=%0d mp=%b expected %0d %0d 1",
                 k, b_branch_cnt, b_mispred_cnt, b_mispredict, ex, ex);
      end
    end
    b_br_valid = 1'b0;
    b_flag_we = 1'b1; b_flag_sel = 2'd3; b_flag_z = 1'b1;
    @(posedge clk);
    #1;
    b_flag_sel = 2'd2;
    @(posedge clk);
    #1;
    b_flag_we = 1'b0; b_flag_z = 1'b0;
    b_br_valid = 1'b1; b_br_code = 3'd2; b_br_acc = 2'd3;
    @(posedge clk);
    #1;
    checks++;
    if (b_taken !== 1'b1 || b_res_valid !== 1'b1) begin
      errors++;
      $display("FAIL acc3_bne: got tk=%b rv=%b expected 1 1", b_taken, b_res_valid);
    end
    b_br_code = 3'd1;
    @(posedge clk);
    #1;
    checks++;
    if (b_taken !== 1'b0) begin
      errors++;
      $display("FAIL acc3_beq: got %b expected 0", b_taken);
    end
    b_br_acc = 2'd2;
    @(posedge clk);
    #1;
    checks++;
    if (b_taken !== 1'b1) begin
      errors++;
      $display("FAIL acc2_beq: got %b expected 1", b_taken);
    end
    b_br_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    issue(1'b1, 3'd7, 0, 10'h005, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got %s expected %s", obs_str(), exp_str(e));
    end
    issue(1'b1, 3'd7, 0, 10'h005, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    b_br_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== 35'd0 ||
        {b_res_valid, b_branch_cnt, b_mispred_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: got %s b_bc=%0d expected all zero", obs_str(), b_branch_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_br_valid = 1'b0;
    model_reset();
    fetch_pc = 10'h005;
    issue(1'b1, 3'd7, 0, 10'h005, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step_pop(e);
    checks++;
    if ({res_valid, taken, mispredict, branch_cnt, mispred_cnt} !== e ||
        branch_cnt !== 16'd1 || mispred_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset: got %s expected %s", obs_str(), exp_str(e));
    end
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pred: got %b expected 1", pred_taken);
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_bypass();
    test_predictor();
    test_codes();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation branch condition unit for the pipelined core.
- Holds registered Z/N/C flags for NUM_ACC accumulators, with same-cycle write bypass.
- Resolves conditional branches against the selected accumulator with a 1-cycle registered result.
- Keeps a BHT of 2-bit saturating predictors, flags mispredictions, and counts branches and mispredictions.

Parameters:
NUM_ACC, 2, number of accumulators with flag sets (1..8)
ACC_W, 1, width of accumulator select; must satisfy 2**ACC_W >= NUM_ACC
PC_W, 10, width of PC inputs
BHT_BITS, 4, log2 of predictor table depth (depth = 2**BHT_BITS)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flag_we  in  1  write flags of accumulator flag_sel
flag_sel  in  ACC_W  accumulator whose flags are written
flag_z  in  1  zero flag to write
flag_n  in  1  sign flag to write
flag_c  in  1  carry flag to write
fetch_pc  in  PC_W  fetch-stage PC used for prediction lookup
pred_taken  out  1  combinational prediction, equal to BHT[fetch_pc[BHT_BITS-1:0]] bit 1
br_valid  in  1  branch presented for resolution this cycle
br_code  in  3  condition: 0 none, 1 EQ(Z=1), 2 NE(Z=0), 3 CS(C=1), 4 CC(C=0), 5 MI(N=1), 6 PL(N=0), 7 ALWAYS
br_acc  in  ACC_W  accumulator tested
br_pc  in  PC_W  PC of the resolving branch, used as BHT index
br_pred  in  1  prediction made at fetch, carried down the pipe
res_valid  out  1  registered: resolution result valid
taken  out  1  registered: branch taken
mispredict  out  1  registered: taken != br_pred; a flush request
branch_cnt  out  CNT_W  resolved-branch counter, saturating
mispred_cnt  out  CNT_W  misprediction counter, saturating

Behaviour:
- Reset: all flag registers 0. res_valid, taken and mispredict 0. Both counters 0. Every BHT entry 2'b01 (weakly not taken).
- Reset is asynchronous. Asserting it mid-operation clears the state the same instant and drops any in-flight result.
- Flag write: on a clk edge with flag_we=1 and flag_sel<NUM_ACC, flags[flag_sel] take {z,n,c}.
- A flag write with flag_sel>=NUM_ACC is ignored.
- Flag source for evaluation:
  - If flag_we=1 and flag_sel==br_acc in the same cycle, the incoming flag_z/n/c are used (bypass).
  - Otherwise the stored flags are used.
  - If br_acc>=NUM_ACC, all flags read as 0.
- Effective branch: br_valid=1 and br_code!=0.
- On a clk edge with an effective branch:
  - res_valid<=1.
  - taken<=condition result. ALWAYS gives 1.
  - mispredict<=(condition result != br_pred).
  - branch_cnt increments, saturating at all-ones.
  - mispred_cnt increments if mispredicted, saturating.
  - BHT[br_pc[BHT_BITS-1:0]] increments (saturating at 11) if taken, otherwise decrements (saturating at 00).
- If br_valid=0 or br_code=0: res_valid, taken and mispredict are cleared to 0 on that edge. Counters and BHT are unchanged.
- Latency: exactly 1 cycle from the branch inputs to res_valid, taken and mispredict. Back-to-back branches resolve every cycle with no bubble.
- pred_taken is combinational on fetch_pc. Same-cycle read-write of one BHT entry returns the old value; the new value is visible the following cycle.
- Two consecutive branches to the same BHT index: the second one sees the first one's update.
- pred_taken is never affected by flags.

Test Plan:
- Reset: drive rst_n=0 mid-stream with br_valid=1 -> all outputs 0 immediately. After release, pred_taken=0 for all 16 fetch_pc values.
- Flags: write acc1 {z=1,n=0,c=0}, then branch EQ on acc1 with br_pred=0 -> next cycle taken=1, mispredict=1, branch_cnt=1, mispred_cnt=1. The same branch on acc0 -> taken=0.
- Bypass: in one cycle, flag_we=1, flag_sel=0, flag_c=1 and BCS on acc0 -> taken=1 (stored flag was 0).
- Predictor: four taken branches at br_pc=0x025 -> BHT[5] goes 01->10->11->11. pred_taken with fetch_pc=0x005 reads 1 from after the first update. Then three not-taken branches -> entry goes 10, 01, 00, and pred_taken reads 0.
- Codes: sweep codes 1..7 over all 8 {z,n,c} combinations -> taken matches the truth table. Code 0 with br_valid=1 -> res_valid=0 and counters unchanged.
- Saturation: with CNT_W=4, resolve 20 mispredicted branches -> both counters stop at 15. br_acc=3 with NUM_ACC=3, ACC_W=2: BNE -> taken=1 and BEQ -> taken=0.
